// File: rtl/addsub_serial_unit.sv
// addsub_serial_unit: digit-serial add/subtract unit with compare flags.
// An N-bit operation is processed K bits per clock through one K-bit adder.
// Operands enter through a valid/ready handshake; the result and flags leave
// through a second one. Partial sums stay internal until the last beat.
module addsub_serial_unit #(
    parameter int N = 32,   // operand/result width
    parameter int K = 8     // chunk width per beat, N % K must be 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic         add_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovfl,
    output logic         zero,
    output logic         altb,
    output logic         altbu,
    output logic         busy
);

    localparam int BEATS = N / K;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    // Operand shift registers: the chunk for the current beat is always the
    // low K bits, so no variable part-select is needed.
    logic [N-1:0]  a_sh;
    logic [N-1:0]  b_sh;      // already inverted for subtract
    logic [N-1:0]  part;      // partial sum, filled from the top
    logic          carry;
    logic          zero_acc;  // OR of all chunk results so far
    logic          a_msb;
    logic          b_msb;     // MSB of the effective (possibly inverted) B
    logic [CW-1:0] beat;

    logic [K-1:0]  chunk_res;
    logic          chunk_cout;
    logic [N-1:0]  part_next;
    logic          last_beat;
    logic          accept;
    logic          ovfl_next;

    assign accept    = (state == IDLE) && in_valid;
    assign last_beat = (beat == CW'(BEATS - 1));

    assign {chunk_cout, chunk_res} = {1'b0, a_sh[K-1:0]} + {1'b0, b_sh[K-1:0]}
                                   + {{K{1'b0}}, carry};

    // New chunk lands in the top K bits; earlier chunks shift down so that
    // after BEATS beats chunk 0 sits at bit 0.
    assign part_next = (part >> K) | (N'(chunk_res) << (N - K));

    // Overflow when both addends share a sign and the result sign differs.
    assign ovfl_next = (a_msb == b_msb) && (chunk_res[K-1] != a_msb);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = RUN;
            RUN:     if (last_beat) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture, per-beat chunk addition, and result/flag update on the
    // final beat. Visible outputs change only when an operation completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            part     <= '0;
            carry    <= 1'b0;
            zero_acc <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            beat     <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovfl     <= 1'b0;
            zero     <= 1'b0;
            altb     <= 1'b0;
            altbu    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh     <= op_a;
                        b_sh     <= add_sub ? ~op_b : op_b;
                        carry    <= add_sub;
                        a_msb    <= op_a[N-1];
                        b_msb    <= op_b[N-1] ^ add_sub;
                        zero_acc <= 1'b0;
                        beat     <= '0;
                    end
                end
                RUN: begin
                    a_sh     <= a_sh >> K;
                    b_sh     <= b_sh >> K;
                    carry    <= chunk_cout;
                    part     <= part_next;
                    zero_acc <= zero_acc | (|chunk_res);
                    beat     <= beat + CW'(1);
                    if (last_beat) begin
                        sum   <= part_next;
                        cout  <= chunk_cout;
                        ovfl  <= ovfl_next;
                        zero  <= ~(zero_acc | (|chunk_res));
                        altb  <= ovfl_next ^ chunk_res[K-1];
                        altbu <= ~chunk_cout;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
